// File: rtl/adc_responder.sv
// adc_responder: serial ADC slave that answers 16-bit SCLK/CS_N frames from a master.
// Define ADC_RESP_TEST_PATTERN_EN to replace ch_data with per-channel counting patterns.
module adc_responder #(
  parameter int         SYNC_STAGES   = 2,
  parameter logic [2:0] RESET_CHANNEL = 3'd0
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        ADC_SCLK,
  input  logic        ADC_CS_N,
  input  logic        ADC_DIN,
  output logic        ADC_DOUT,
  input  logic [11:0] ch_data,
  output logic [2:0]  ch_sel,
  output logic [11:0] ctrl_word,
  output logic        frame_done,
  output logic        frame_abort
);

  typedef enum logic [1:0] {IDLE, SHIFT, TAIL} state_t;

  localparam logic [2:0] SETTLE = 3'(SYNC_STAGES);

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, din_sync;
  logic        sclk_p0, cs_p0, din_p0;
  logic        sclk_p1, cs_p1;
  logic        sclk_fall, sclk_rise, cs_fall, cs_rise;
  logic [2:0]  settle;
  logic        armed;

  state_t      state, state_d;
  logic [4:0]  fall_cnt, fall_cnt_d;
  logic [14:0] frame, frame_d;
  logic [11:0] ctrl_sr, ctrl_sr_d, ctrl_word_d;
  logic [2:0]  ch_sel_d;
  logic        dout_d, done_d, abort_d;
  logic [11:0] sample;

  // Stage p0: synchronizer chains; stage p1: edge-detect register
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sclk_sync <= '1;
      cs_sync   <= '1;
      din_sync  <= '0;
      sclk_p1   <= 1'b1;
      cs_p1     <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], ADC_SCLK};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], ADC_CS_N};
      din_sync  <= {din_sync[SYNC_STAGES-2:0], ADC_DIN};
      sclk_p1   <= sclk_p0;
      cs_p1     <= cs_p0;
    end
  end

  assign sclk_p0   = sclk_sync[SYNC_STAGES-1];
  assign cs_p0     = cs_sync[SYNC_STAGES-1];
  assign din_p0    = din_sync[SYNC_STAGES-1];
  assign sclk_fall = sclk_p1 & ~sclk_p0;
  assign sclk_rise = ~sclk_p1 & sclk_p0;
  assign cs_fall   = cs_p1 & ~cs_p0;
  assign cs_rise   = ~cs_p1 & cs_p0;

  // The chains reset to idle-high, so a CS_N held low through reset would look like
  // a fresh falling edge; frames are accepted only after CS_N is genuinely seen high.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      settle <= '0;
      armed  <= 1'b0;
    end else if (settle != SETTLE) begin
      settle <= settle + 3'd1;
    end else if (cs_p0) begin
      armed  <= 1'b1;
    end
  end

`ifdef ADC_RESP_TEST_PATTERN_EN
  logic [8:0] pat_cnt [8];
  logic [2:0] frame_ch;
  logic       unused_ch_data;

  assign unused_ch_data = ^ch_data;
  assign sample         = {ch_sel, pat_cnt[ch_sel]};

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) pat_cnt[i] <= '0;
      frame_ch <= '0;
    end else begin
      if (state == IDLE && state_d == SHIFT) frame_ch <= ch_sel;
      if (done_d) pat_cnt[frame_ch] <= pat_cnt[frame_ch] + 9'd1;
    end
  end
`else
  assign sample = ch_data;
`endif

  always_comb begin
    state_d     = state;
    fall_cnt_d  = fall_cnt;
    frame_d     = frame;
    ctrl_sr_d   = ctrl_sr;
    ctrl_word_d = ctrl_word;
    ch_sel_d    = ch_sel;
    dout_d      = ADC_DOUT;
    done_d      = 1'b0;
    abort_d     = 1'b0;
    unique case (state)
      IDLE: begin
        dout_d = 1'b0;
        if (armed && cs_fall) begin
          state_d    = SHIFT;
          frame_d    = {ch_sel, sample};
          fall_cnt_d = '0;
          ctrl_sr_d  = '0;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d = IDLE;
          abort_d = 1'b1;
          dout_d  = 1'b0;
        end else if (sclk_fall) begin
          fall_cnt_d = fall_cnt + 5'd1;
          if (fall_cnt < 5'd12) ctrl_sr_d = {ctrl_sr[10:0], din_p0};
          // frame holds bits 14:0 left-aligned; each fall after the first exposes the next one
          if (fall_cnt != 5'd0) begin
            dout_d  = frame[14];
            frame_d = {frame[13:0], 1'b0};
          end
          if (fall_cnt == 5'd15) state_d = TAIL;
        end
      end
      TAIL: begin
        if (cs_rise) begin
          state_d = IDLE;
          done_d  = 1'b1;
          dout_d  = 1'b0;
          if (ctrl_sr[11]) begin
            ctrl_word_d = ctrl_sr;
            ch_sel_d    = ctrl_sr[8:6];
          end
        end else if (sclk_rise) begin
          // bit 0 stays up until the master has clocked it in on the 16th rise
          dout_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state       <= IDLE;
      fall_cnt    <= '0;
      frame       <= '0;
      ctrl_sr     <= '0;
      ctrl_word   <= '0;
      ch_sel      <= RESET_CHANNEL;
      ADC_DOUT    <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      state       <= state_d;
      fall_cnt    <= fall_cnt_d;
      frame       <= frame_d;
      ctrl_sr     <= ctrl_sr_d;
      ctrl_word   <= ctrl_word_d;
      ch_sel      <= ch_sel_d;
      ADC_DOUT    <= dout_d;
      frame_done  <= done_d;
      frame_abort <= abort_d;
    end
  end

endmodule

// File: tb/tb_adc_responder.sv
// Bench for adc_responder: bit-banged master frames checked against a frame-level model.
module tb_adc_responder;

  localparam int         S      = 2;
  localparam logic [2:0] RST_CH = 3'd0;
  localparam int         HALF   = 8;

  logic        CLOCK_50 = 1'b0;
  logic        reset    = 1'b0;
  logic        ADC_SCLK = 1'b1;
  logic        ADC_CS_N = 1'b1;
  logic        ADC_DIN  = 1'b0;
  logic        ADC_DOUT;
  logic [11:0] ch_data  = '0;
  logic [2:0]  ch_sel;
  logic [11:0] ctrl_word;
  logic        frame_done, frame_abort;

  int checks = 0, errors = 0;
  int done_cnt = 0, abort_cnt = 0;

  logic [2:0]  m_sel;
  logic [11:0] m_word;
  int          m_cnt [8];

  adc_responder #(.SYNC_STAGES(S), .RESET_CHANNEL(RST_CH)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .ADC_SCLK(ADC_SCLK), .ADC_CS_N(ADC_CS_N),
    .ADC_DIN(ADC_DIN), .ADC_DOUT(ADC_DOUT), .ch_data(ch_data), .ch_sel(ch_sel),
    .ctrl_word(ctrl_word), .frame_done(frame_done), .frame_abort(frame_abort)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(negedge CLOCK_50) begin
    if (frame_done === 1'b1) done_cnt++;
    if (frame_abort === 1'b1) abort_cnt++;
  end

  // Reference model: frame contents and what a completed frame commits
  task automatic model_reset();
    m_sel  = RST_CH;
    m_word = '0;
    for (int i = 0; i < 8; i++) m_cnt[i] = 0;
  endtask

  function automatic logic [15:0] model_bits();
`ifdef ADC_RESP_TEST_PATTERN_EN
    return {1'b0, m_sel, m_sel, 9'(m_cnt[m_sel])};
`else
    return {1'b0, m_sel, ch_data};
`endif
  endfunction

  task automatic model_end(input logic [11:0] word, input int nfalls);
    if (nfalls >= 16) begin
      m_cnt[m_sel] = (m_cnt[m_sel] + 1) % 512;
      // first bit received is WRITE, the 4th..6th are ADD2..ADD0
      if (word[11]) begin
        m_word = word;
        m_sel  = word[8:6];
      end
    end
  endtask

  function automatic logic [15:0] frame_mask(input int nfalls);
    logic [15:0] m = 16'h8000;
    for (int n = 2; n <= 16; n++) if (n <= nfalls) m[16-n] = 1'b1;
    return m;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  // Master side of one frame; bits[15-k] is DOUT as seen before the (k+1)-th rise
  task automatic run_frame(input logic [11:0] word, input int nfalls, input bit sim_start,
                           output logic [15:0] bits, output bit tail_ok);
    bits    = '0;
    tail_ok = 1'b1;
    ADC_DIN  = word[11];
    ADC_CS_N = 1'b0;
    if (sim_start) begin
      ADC_SCLK = 1'b0;
      tick(HALF);
      ADC_SCLK = 1'b1;
    end
    tick(HALF);
    bits[15] = ADC_DOUT;
    for (int n = 1; n <= nfalls; n++) begin
      ADC_SCLK = 1'b0;
      tick(S + 2);
      if (n >= 2 && n <= 16) bits[16-n] = ADC_DOUT;
      if (n > 16 && ADC_DOUT !== 1'b0) tail_ok = 1'b0;
      tick(HALF - (S + 2));
      ADC_SCLK = 1'b1;
      ADC_DIN  = (n < 12) ? word[11-n] : 1'($urandom_range(0, 1));
      tick(HALF);
    end
    ADC_CS_N = 1'b1;
    tick(HALF);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    model_reset();
    checks++; if (ch_sel !== RST_CH) begin errors++; $display("FAIL reset_ch_sel got %h want %h", ch_sel, RST_CH); end
    checks++; if (ctrl_word !== 12'h000) begin errors++; $display("FAIL reset_ctrl_word got %h want 000", ctrl_word); end
    checks++; if (ADC_DOUT !== 1'b0) begin errors++; $display("FAIL reset_dout got %b want 0", ADC_DOUT); end
    checks++; if (frame_done !== 1'b0 || frame_abort !== 1'b0) begin
      errors++; $display("FAIL reset_pulses got %b%b want 00", frame_done, frame_abort);
    end
    tick(HALF);
  endtask

  task automatic test_basic();
    logic [11:0] words [3] = '{12'h831, 12'h8F1, 12'h0F1};
    logic [11:0] datas [3] = '{12'hA5C, 12'h123, 12'h456};
    logic [15:0] bits, exp;
    bit tail_ok;
    int d0, a0;
    for (int i = 0; i < 3; i++) begin
      ch_data = datas[i];
      d0 = done_cnt; a0 = abort_cnt;
      exp = model_bits();
      run_frame(words[i], 16, 1'b0, bits, tail_ok);
      model_end(words[i], 16);
      checks++; if (bits !== exp) begin errors++; $display("FAIL basic_bits[%0d] got %h want %h", i, bits, exp); end
      checks++; if (done_cnt - d0 != 1 || abort_cnt != a0) begin
        errors++; $display("FAIL basic_pulses[%0d] got done %0d abort %0d want 1 0", i, done_cnt - d0, abort_cnt - a0);
      end
      checks++; if (ch_sel !== m_sel) begin errors++; $display("FAIL basic_ch_sel[%0d] got %h want %h", i, ch_sel, m_sel); end
      checks++; if (ctrl_word !== m_word) begin errors++; $display("FAIL basic_ctrl_word[%0d] got %h want %h", i, ctrl_word, m_word); end
`ifndef ADC_RESP_TEST_PATTERN_EN
      if (i == 0) begin
        checks++; if (bits !== 16'h0A5C) begin errors++; $display("FAIL basic_first_frame got %h want 0a5c", bits); end
      end
`endif
      if (i == 2) begin
        checks++; if (bits[14:12] !== 3'b011) begin errors++; $display("FAIL basic_ch3_bits got %b want 011", bits[14:12]); end
      end
    end
  endtask

  task automatic test_abort();
    logic [15:0] bits, exp, mask;
    bit tail_ok;
    int d0, a0;
    ch_data = 12'h9E7;
    d0 = done_cnt; a0 = abort_cnt;
    exp = model_bits(); mask = frame_mask(8);
    run_frame(12'h8C0, 8, 1'b0, bits, tail_ok);
    model_end(12'h8C0, 8);
    checks++; if ((bits & mask) !== (exp & mask)) begin errors++; $display("FAIL abort_bits got %h want %h", bits & mask, exp & mask); end
    checks++; if (abort_cnt - a0 != 1 || done_cnt != d0) begin
      errors++; $display("FAIL abort_pulses got done %0d abort %0d want 0 1", done_cnt - d0, abort_cnt - a0);
    end
    checks++; if (ch_sel !== m_sel || ctrl_word !== m_word) begin
      errors++; $display("FAIL abort_state got %h/%h want %h/%h", ch_sel, ctrl_word, m_sel, m_word);
    end
    checks++; if (ADC_DOUT !== 1'b0) begin errors++; $display("FAIL abort_idle_dout got %b want 0", ADC_DOUT); end
  endtask

  task automatic test_simultaneous();
    logic [15:0] bits, exp;
    bit tail_ok;
    int d0, a0;
    for (int k = 0; k < 2; k++) begin
      int nf = 15 + k;
      ch_data = 12'h3C5 + 12'(k);
      d0 = done_cnt; a0 = abort_cnt;
      exp = model_bits() & frame_mask(nf);
      run_frame(12'h940, nf, 1'b1, bits, tail_ok);
      model_end(12'h940, nf);
      checks++; if ((bits & frame_mask(nf)) !== exp) begin
        errors++; $display("FAIL simul_bits[%0d] got %h want %h", k, bits & frame_mask(nf), exp);
      end
      checks++; if (done_cnt - d0 != k || abort_cnt - a0 != 1 - k) begin
        errors++; $display("FAIL simul_pulses[%0d] got done %0d abort %0d want %0d %0d", k, done_cnt - d0, abort_cnt - a0, k, 1 - k);
      end
      checks++; if (ch_sel !== m_sel) begin errors++; $display("FAIL simul_ch_sel[%0d] got %h want %h", k, ch_sel, m_sel); end
    end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] bits, exp;
    bit tail_ok;
    int d0, a0;
    ADC_DIN  = 1'b1;
    ADC_CS_N = 1'b0;
    tick(HALF);
    for (int n = 0; n < 5; n++) begin
      ADC_SCLK = 1'b0; tick(HALF);
      ADC_SCLK = 1'b1; tick(HALF);
    end
    d0 = done_cnt; a0 = abort_cnt;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    model_reset();
    checks++; if (ADC_DOUT !== 1'b0) begin errors++; $display("FAIL midreset_dout got %b want 0", ADC_DOUT); end
    checks++; if (ch_sel !== RST_CH || ctrl_word !== 12'h000) begin
      errors++; $display("FAIL midreset_state got %h/%h want %h/000", ch_sel, ctrl_word, RST_CH);
    end
    for (int n = 0; n < 11; n++) begin
      ADC_SCLK = 1'b0; tick(HALF);
      ADC_SCLK = 1'b1; tick(HALF);
    end
    ADC_CS_N = 1'b1;
    tick(HALF);
    checks++; if (done_cnt != d0 || abort_cnt != a0) begin
      errors++; $display("FAIL midreset_pulses got done %0d abort %0d want 0 0", done_cnt - d0, abort_cnt - a0);
    end
    checks++; if (ch_sel !== RST_CH || ctrl_word !== 12'h000) begin
      errors++; $display("FAIL midreset_held got %h/%h want %h/000", ch_sel, ctrl_word, RST_CH);
    end
    // a full write frame selecting channel 2, then plain reads of channel 2
    for (int i = 0; i < 4; i++) begin
      logic [11:0] w = (i == 0) ? 12'h880 : 12'h000;
      ch_data = 12'h5A0 + 12'(i);
      d0 = done_cnt;
      exp = model_bits();
      run_frame(w, 16, 1'b0, bits, tail_ok);
      model_end(w, 16);
      checks++; if (bits !== exp) begin errors++; $display("FAIL after_reset_bits[%0d] got %h want %h", i, bits, exp); end
      checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL after_reset_done[%0d] got %0d want 1", i, done_cnt - d0); end
`ifdef ADC_RESP_TEST_PATTERN_EN
      if (i > 0) begin
        checks++; if (bits[11:0] !== 12'h400 + 12'(i - 1)) begin
          errors++; $display("FAIL pattern_ch2[%0d] got %h want %h", i, bits[11:0], 12'h400 + 12'(i - 1));
        end
      end
`endif
    end
    checks++; if (ch_sel !== 3'd2) begin errors++; $display("FAIL after_reset_ch_sel got %h want 2", ch_sel); end
  endtask

  task automatic test_random();
    logic [15:0] bits, exp, mask;
    logic [11:0] word;
    bit tail_ok;
    int d0, a0, nf, kind, want_done;
    for (int i = 0; i < 24; i++) begin
      ch_data = 12'($urandom);
      word    = 12'($urandom);
      kind    = $urandom_range(0, 3);
      nf      = (kind == 0) ? $urandom_range(0, 15) : (kind == 3) ? $urandom_range(17, 20) : 16;
      want_done = (nf >= 16) ? 1 : 0;
      d0 = done_cnt; a0 = abort_cnt;
      exp = model_bits(); mask = frame_mask(nf);
      run_frame(word, nf, 1'b0, bits, tail_ok);
      model_end(word, nf);
      checks++; if ((bits & mask) !== (exp & mask)) begin
        errors++; $display("FAIL rand_bits[%0d] nf %0d got %h want %h", i, nf, bits & mask, exp & mask);
      end
      checks++; if (done_cnt - d0 != want_done || abort_cnt - a0 != 1 - want_done) begin
        errors++; $display("FAIL rand_pulses[%0d] got done %0d abort %0d want %0d %0d", i, done_cnt - d0, abort_cnt - a0, want_done, 1 - want_done);
      end
      checks++; if (ch_sel !== m_sel || ctrl_word !== m_word) begin
        errors++; $display("FAIL rand_state[%0d] got %h/%h want %h/%h", i, ch_sel, ctrl_word, m_sel, m_word);
      end
      checks++; if (ADC_DOUT !== 1'b0) begin errors++; $display("FAIL rand_idle_dout[%0d] got %b want 0", i, ADC_DOUT); end
      checks++; if (!tail_ok) begin errors++; $display("FAIL rand_tail_dout[%0d] got 1 want 0", i); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_abort();
    test_simultaneous();
    test_reset_midframe();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
